spi_seg_receiver: RTL and testbench
===================================

SPI_SEG_RECEIVER -- requirements
Module: spi_seg_receiver

Interface
- REQ-001 SHALL have parameter MAX_COUNT, default 24'd10_000_000, giving the clk cycles per blink phase toggle.
- REQ-002 SHALL have port clk, input, 1, system clock; the block uses this single clock.
- REQ-003 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
- REQ-004 SHALL have port sclk, input, 1, SPI clock; asynchronous to clk.
- REQ-005 SHALL have port cs_n, input, 1, SPI chip select; active-low, asynchronous to clk.
- REQ-006 SHALL have port mosi, input, 1, SPI serial data in.
- REQ-007 SHALL have port miso, output, 1, SPI serial data out.
- REQ-008 SHALL have port seg_out, output, 8, segment drive to the display top.
- REQ-009 SHALL have port upd, output, 1, one-cycle pulse on each accepted write.
- REQ-010 SHALL have port frame_err, output, 1, one-cycle pulse on each rejected frame.

Function
- REQ-011 SHALL synchronise sclk, cs_n and mosi through 2 flops each, then detect sclk edges by comparing against a third flop.
- REQ-012 SHALL support only SPI mode 0, MSB first; mosi sampled on a detected sclk rise; sclk frequency at most clk/8.
- REQ-013 SHALL use frame = 8-bit command, then 8-bit data, all within one cs_n low period.
- REQ-014 SHALL implement FSM IDLE -> CMD on cs_n fall; CMD -> DATA after the 8th bit; DATA -> HOLD after the 16th bit; any state -> IDLE on cs_n rise.
- REQ-015 SHALL, on the 16th bit, act on the command: 0x01 loads seg_reg with the data byte; 0x02 loads blink_mask with the data byte; any other command leaves both registers unchanged and pulses frame_err.
- REQ-016 SHALL pulse upd for exactly one cycle, on the cycle seg_reg or blink_mask changes.
- REQ-017 SHALL update seg_out and upd no later than 4 clk cycles after the 16th sclk rise at the pin.
- REQ-018 SHALL ignore sclk edges in HOLD (extra bits dropped, no second write).
- REQ-019 SHALL, on cs_n rise in CMD or DATA (fewer than 16 bits), discard the partial frame and pulse frame_err once; cs_n rise in HOLD or IDLE SHALL NOT pulse frame_err.
- REQ-020 SHALL run a 24-bit blink counter that counts 0..MAX_COUNT-1, wraps to 0, and toggles blink phase on wrap.
- REQ-021 SHALL compute seg_out = seg_reg AND NOT (blink_mask AND {8{phase}}), registered.
- REQ-022 SHALL NOT let a simultaneous register write and phase toggle interfere: both take effect on the same edge.

Reset
- REQ-023 SHALL, on rst_n low, immediately clear seg_reg, blink_mask, seg_out, counter, phase, upd, frame_err and miso to 0, and set the FSM to IDLE.
- REQ-024 SHALL abandon a frame in progress on reset with no write, and restart only on the next cs_n fall after release.

Configuration
- REQ-025 SHALL, with SPI_READBACK_EN defined, drive miso with seg_reg MSB first during DATA: bit 7 on entry to DATA, next bit after each detected sclk fall, and 0 elsewhere.
- REQ-026 SHALL, without SPI_READBACK_EN, hold miso constant 0 and omit the readback shifter.

Verification
- REQ-027 SHALL check frame 0x01,0xA5 -> seg_out=0xA5 within 4 clk, a single upd pulse, frame_err=0.
- REQ-028 SHALL check frame 0x02,0x0F after seg=0xFF, with MAX_COUNT=4 -> seg_out alternates 0xFF/0xF0 every 4 clk.
- REQ-029 SHALL check cs_n rise after 11 bits -> one frame_err pulse, seg_out unchanged.
- REQ-030 SHALL check frame 0x7E,0x12 -> frame_err pulse, seg_out and blink unchanged; a 20-bit frame 0x01,0x3C,+4 bits -> seg_out=0x3C, one upd.
- REQ-031 SHALL check rst_n low mid-frame after 12 bits -> all outputs 0 asynchronously; the next full frame 0x01,0x81 -> seg_out=0x81.
- REQ-032 SHALL check, with SPI_READBACK_EN and seg_reg=0xC3, frame 0x01,0x00 -> miso bits in DATA = 1,1,0,0,0,0,1,1; without the macro, miso=0 throughout.

Source files
------------

// File: rtl/spi_seg_receiver.sv
// SPI mode-0 slave that writes a segment register / blink mask and drives a blinking 8-bit display.
// Optional readback of seg_reg on miso during the data byte: define SPI_READBACK_EN.
module spi_seg_receiver #(
  parameter logic [23:0] MAX_COUNT = 24'd10_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       cs_n,
  input  logic       mosi,
  output logic       miso,
  output logic [7:0] seg_out,
  output logic       upd,
  output logic       frame_err
);

  typedef enum logic [1:0] {IDLE, CMD, DATA, HOLD} state_t;

  state_t      state, state_next;
  logic [2:0]  sclk_s, cs_s;
  logic [1:0]  mosi_s;
  logic        sclk_rise, cs_fall, cs_rise;
  logic [3:0]  bit_cnt;
  logic [7:0]  shreg, cmd_reg, data_byte;
  logic [7:0]  seg_reg, blink_mask, seg_d, mask_d;
  logic [23:0] cnt;
  logic        phase, phase_d, cnt_wrap;
  logic        shift_en, wr_seg, wr_mask, err;

  // Sync flops reset low so a cs_n held low across reset cannot look like a fresh frame start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_s <= '0;
      cs_s   <= '0;
      mosi_s <= '0;
    end else begin
      sclk_s <= {sclk_s[1:0], sclk};
      cs_s   <= {cs_s[1:0], cs_n};
      mosi_s <= {mosi_s[0], mosi};
    end
  end

  assign sclk_rise = sclk_s[1] & ~sclk_s[2];
  assign cs_fall   = ~cs_s[1] & cs_s[2];
  assign cs_rise   = cs_s[1] & ~cs_s[2];
  assign data_byte = {shreg[6:0], mosi_s[1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    shift_en   = 1'b0;
    wr_seg     = 1'b0;
    wr_mask    = 1'b0;
    err        = 1'b0;
    if (cs_rise) begin
      state_next = IDLE;
      err        = (state == CMD) || (state == DATA);
    end else begin
      case (state)
        IDLE: if (cs_fall) state_next = CMD;
        CMD: if (sclk_rise) begin
          shift_en = 1'b1;
          if (bit_cnt == 4'd7) state_next = DATA;
        end
        DATA: if (sclk_rise) begin
          shift_en = 1'b1;
          if (bit_cnt == 4'd15) begin
            state_next = HOLD;
            case (cmd_reg)
              8'h01:   wr_seg  = 1'b1;
              8'h02:   wr_mask = 1'b1;
              default: err     = 1'b1;
            endcase
          end
        end
        default: state_next = state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt <= '0;
      shreg   <= '0;
      cmd_reg <= '0;
    end else if (state == IDLE) begin
      bit_cnt <= '0;
    end else if (shift_en) begin
      bit_cnt <= bit_cnt + 4'd1;
      shreg   <= data_byte;
      if (state == CMD && bit_cnt == 4'd7) cmd_reg <= data_byte;
    end
  end

  assign cnt_wrap = (cnt == MAX_COUNT - 24'd1);
  assign phase_d  = phase ^ cnt_wrap;
  assign seg_d    = wr_seg  ? data_byte : seg_reg;
  assign mask_d   = wr_mask ? data_byte : blink_mask;

  // seg_out is built from next-state values so a write and a phase toggle land on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      phase      <= 1'b0;
      seg_reg    <= '0;
      blink_mask <= '0;
      seg_out    <= '0;
      upd        <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      cnt        <= cnt_wrap ? 24'd0 : cnt + 24'd1;
      phase      <= phase_d;
      seg_reg    <= seg_d;
      blink_mask <= mask_d;
      seg_out    <= seg_d & ~(mask_d & {8{phase_d}});
      upd        <= wr_seg | wr_mask;
      frame_err  <= err;
    end
  end

`ifdef SPI_READBACK_EN
  logic       sclk_fall;
  logic [7:0] rb_shift;

  assign sclk_fall = ~sclk_s[1] & sclk_s[2];

  // The fall right after the 8th rise still belongs to the command byte, so shifting starts from bit 9.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rb_shift <= '0;
      miso     <= 1'b0;
    end else if (state == CMD && state_next == DATA) begin
      rb_shift <= seg_reg;
      miso     <= seg_reg[7];
    end else if (state == DATA && state_next == DATA && sclk_fall && bit_cnt >= 4'd9) begin
      rb_shift <= {rb_shift[6:0], 1'b0};
      miso     <= rb_shift[6];
    end else if (state_next != DATA) begin
      miso     <= 1'b0;
    end
  end
`else
  assign miso = 1'b0;
`endif

endmodule

// File: tb/tb_spi_seg_receiver.sv
// Directed bench for spi_seg_receiver: writes, partial/invalid/overlong frames, reset, blink, readback.
module tb_spi_seg_receiver;

  localparam int H = 4;

  logic       clk, rst_n, sclk, cs_n, mosi;
  logic       miso, upd, frame_err;
  logic [7:0] seg_out;

  int n_chk, n_pass;
  int cyc, t16, lat, n_upd, n_err, bit_no;
  logic [31:0] rb_acc;

  spi_seg_receiver #(.MAX_COUNT(24'd4)) dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .miso(miso), .seg_out(seg_out), .upd(upd), .frame_err(frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (upd) begin
      n_upd++;
      lat = cyc - t16;
    end
    if (frame_err) n_err++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic spi_bit(input logic b);
    mosi = b;
    repeat (H) @(negedge clk);
    rb_acc = {rb_acc[30:0], miso};
    bit_no++;
    sclk = 1'b1;
    if (bit_no == 16) t16 = cyc;
    repeat (H) @(negedge clk);
    sclk = 1'b0;
  endtask

  task automatic frame(input logic [31:0] bits, input int n);
    @(negedge clk);
    cs_n   = 1'b0;
    bit_no = 0;
    rb_acc = '0;
    lat    = 99;
    repeat (H) @(negedge clk);
    for (int i = n - 1; i >= 0; i--) spi_bit(bits[i]);
    repeat (H) @(negedge clk);
    cs_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  int         u0, e0;
  logic [7:0] prev, cur, other;
  logic       changed;

  initial begin
    n_chk = 0; n_pass = 0; cyc = 0; t16 = 0; lat = 99; n_upd = 0; n_err = 0;
    bit_no = 0; rb_acc = '0;
    rst_n = 1'b0; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_seg", seg_out, 0);
    chk("rst_upd", upd, 0);
    chk("rst_err", frame_err, 0);
    chk("rst_miso", miso, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Plain write
    u0 = n_upd; e0 = n_err;
    frame(32'h01A5, 16);
    chk("w1_seg", seg_out, 8'hA5);
    chk("w1_upd", n_upd - u0, 1);
    chk("w1_err", n_err - e0, 0);
    chk("w1_lat", lat <= 4, 1);

    // Truncated frame after 11 bits
    u0 = n_upd; e0 = n_err;
    frame(32'h0000_05AB, 11);
    chk("short_err", n_err - e0, 1);
    chk("short_upd", n_upd - u0, 0);
    chk("short_seg", seg_out, 8'hA5);

    // Unknown command
    u0 = n_upd; e0 = n_err;
    frame(32'h7E12, 16);
    chk("bad_err", n_err - e0, 1);
    chk("bad_upd", n_upd - u0, 0);
    for (int i = 0; i < 8; i++) begin
      chk("bad_seg", seg_out, 8'hA5);
      @(negedge clk);
    end

    // Overlong frame: extra bits dropped in HOLD
    u0 = n_upd; e0 = n_err;
    frame(32'h013C5, 20);
    chk("long_seg", seg_out, 8'h3C);
    chk("long_upd", n_upd - u0, 1);
    chk("long_err", n_err - e0, 0);

    // Reset mid-frame after 12 bits
    @(negedge clk);
    cs_n = 1'b0; bit_no = 0;
    repeat (H) @(negedge clk);
    for (int i = 11; i >= 0; i--) spi_bit(i[0]);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_seg", seg_out, 0);
    chk("arst_upd", upd, 0);
    chk("arst_err", frame_err, 0);
    chk("arst_miso", miso, 0);
    cs_n = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    u0 = n_upd; e0 = n_err;
    frame(32'h0181, 16);
    chk("post_rst_seg", seg_out, 8'h81);
    chk("post_rst_upd", n_upd - u0, 1);
    chk("post_rst_err", n_err - e0, 0);

    // Blink: low nibble masked, phase toggles every 4 clk
    frame(32'h01FF, 16);
    chk("blk_base", seg_out, 8'hFF);
    u0 = n_upd;
    frame(32'h020F, 16);
    chk("blk_upd", n_upd - u0, 1);
    prev = seg_out;
    changed = 1'b0;
    for (int i = 0; i < 8 && !changed; i++) begin
      @(negedge clk);
      if (seg_out !== prev) changed = 1'b1;
    end
    chk("blk_edge", changed, 1);
    cur = seg_out;
    other = (cur == 8'hFF) ? 8'hF0 : 8'hFF;
    chk("blk_val", (cur == 8'hFF) || (cur == 8'hF0), 1);
    for (int i = 0; i < 12; i++) begin
      chk("blk_seq", seg_out, ((i / 4) % 2 == 0) ? cur : other);
      @(negedge clk);
    end
    frame(32'h0200, 16);
    repeat (8) begin
      chk("unblk", seg_out, 8'hFF);
      @(negedge clk);
    end

    // Readback of the previous seg_reg during the data byte
    frame(32'h01C3, 16);
    chk("rb_pre", seg_out, 8'hC3);
    frame(32'h0100, 16);
`ifdef SPI_READBACK_EN
    chk("rb_miso", rb_acc[15:0], 16'h00C3);
`else
    chk("rb_miso", rb_acc[15:0], 16'h0000);
`endif
    chk("rb_seg", seg_out, 8'h00);
    chk("rb_idle", miso, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
